fetch_unit: RTL
===============

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 64'h0: PC value loaded on reset.
REQ-002 Parameter TIMEOUT_CYCLES, default 16: fetch-wait limit, used only when FETCH_TIMEOUT_EN is defined.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 imem_req  output  1  instruction-memory read request.
REQ-006 imem_addr  output  64  byte address of the requested word; equals pc.
REQ-007 imem_valid  input  1  imem_rdata valid this cycle.
REQ-008 imem_rdata  input  32  instruction word.
REQ-009 instr_out  output  32  held instruction; this bus feeds the sign-extend and decode stage.
REQ-010 instr_pc  output  64  address of instr_out.
REQ-011 instr_valid  output  1  instr_out is valid.
REQ-012 instr_ready  input  1  downstream accepts instr_out.
REQ-013 br_taken  input  1  the accepted instruction redirects the PC.
REQ-014 br_offset  input  64  sign-extended word offset from the sign-extend stage.
REQ-015 fetch_fault  output  1  sticky fetch-timeout flag.

Function
REQ-016 The FSM SHALL have states IDLE, FETCH, HOLD and, only when FETCH_TIMEOUT_EN is defined, FAULT.
REQ-017 IDLE SHALL last exactly one cycle, with imem_req=0, and then go to FETCH.
REQ-018 FETCH SHALL assert imem_req=1 with imem_addr=pc each cycle until imem_valid=1.
REQ-019 On that edge the unit SHALL capture imem_rdata into instr_out and pc into instr_pc, then go to HOLD.
REQ-020 In HOLD the unit SHALL drive imem_req=0 and instr_valid=1, holding instr_out and instr_pc stable until instr_valid and instr_ready are both 1.
REQ-021 On the accept edge, the new pc SHALL be instr_pc + (br_offset << 2) if br_taken=1, else instr_pc + 4; the FSM then goes to FETCH.
REQ-022 All PC arithmetic SHALL be modulo 2^64:
- 64'hFFFF_FFFF_FFFF_FFFC + 4 = 0.
- A negative offset wraps below 0.
REQ-023 br_taken and br_offset SHALL be sampled only on the accept edge and ignored otherwise.
REQ-024 imem_valid outside FETCH SHALL be ignored and SHALL change no state.
REQ-025 Throughput SHALL be one instruction per two cycles with zero-wait memory and instr_ready held at 1.
REQ-026 instr_valid SHALL be 0 in every state except HOLD.

Reset
REQ-027 While reset=0, asynchronously:
- state=IDLE, pc=RESET_PC.
- instr_out=0, instr_pc=0.
- instr_valid=0, imem_req=0, fetch_fault=0.
- timeout counter=0.
REQ-028 Reset asserted mid-FETCH or mid-HOLD SHALL discard the pending request or instruction; the first request after release SHALL use RESET_PC.

Configuration
REQ-029 When FETCH_TIMEOUT_EN is defined, a counter SHALL:
- clear on entering FETCH;
- increment each FETCH cycle in which imem_valid=0;
- on reaching TIMEOUT_CYCLES, set fetch_fault=1, go to FAULT and drive imem_req=0.
REQ-030 FAULT SHALL be left only by reset, and fetch_fault SHALL stay 1 until reset.
REQ-031 When FETCH_TIMEOUT_EN is undefined, there SHALL be no counter and no FAULT state, fetch_fault SHALL be tied to 0, and FETCH SHALL wait indefinitely.

Structure
REQ-032 The shared package fetch_pkg SHALL hold:
- the FSM state enum;
- ADDR_W=64 and INSTR_W=32;
- the constant PC_STEP=4.
REQ-033 Next-PC computation SHALL live in one combinational sub-module, branch_target_adder, with inputs pc, br_offset and br_taken and output next_pc.

Verification
REQ-034 Reset release, zero-wait memory returning 32'hF8400020 -> imem_req rises on cycle 2 with addr 0; instr_out=32'hF8400020 with instr_pc=0 one cycle later.
REQ-035 Sequential fetch with instr_ready=1 and br_taken=0 -> addresses 0, 4, 8, 12 issued every two cycles.
REQ-036 Accept at instr_pc=64'h40 with br_taken=1 and br_offset=64'hFFFF_FFFF_FFFF_FFFC -> next imem_addr=64'h30.
REQ-037 pc=64'hFFFF_FFFF_FFFF_FFFC, no branch -> next imem_addr=0; instr_ready held at 0 for 5 cycles -> instr_out and instr_pc unchanged and imem_req=0 throughout.
REQ-038 With FETCH_TIMEOUT_EN defined and imem_valid held at 0 -> fetch_fault=1 after 16 FETCH cycles and imem_req=0; after a reset pulse, fetch_fault=0 and fetch restarts at RESET_PC.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch slice: FSM state encoding,
// bus widths and the sequential PC step.
// Optional feature macro: FETCH_TIMEOUT_EN adds the FAULT state.
package fetch_pkg;

    localparam int ADDR_W  = 64;
    localparam int INSTR_W = 32;

    localparam logic [ADDR_W-1:0] PC_STEP = 64'd4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2
`ifdef FETCH_TIMEOUT_EN
        ,
        FAULT = 2'd3
`endif
    } fetch_state_t;

    // Branch offsets arrive in instruction words; the PC counts bytes.
    function automatic logic [ADDR_W-1:0] word_to_byte_offset(input logic [ADDR_W-1:0] word_offset);
        return word_offset << 2;
    endfunction

endpackage

// File: rtl/fetch_if.sv
// Handshake bundle between the fetch unit, instruction memory and the
// sign-extend/decode stage. The master modport is the fetch unit's view.
interface fetch_if;

    logic                           imem_req;
    logic [fetch_pkg::ADDR_W-1:0]   imem_addr;
    logic                           imem_valid;
    logic [fetch_pkg::INSTR_W-1:0]  imem_rdata;

    logic [fetch_pkg::INSTR_W-1:0]  instr_out;
    logic [fetch_pkg::ADDR_W-1:0]   instr_pc;
    logic                           instr_valid;
    logic                           instr_ready;
    logic                           br_taken;
    logic [fetch_pkg::ADDR_W-1:0]   br_offset;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_valid,
        input  imem_rdata,
        output instr_out,
        output instr_pc,
        output instr_valid,
        input  instr_ready,
        input  br_taken,
        input  br_offset
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_valid,
        output imem_rdata,
        input  instr_out,
        input  instr_pc,
        input  instr_valid,
        output instr_ready,
        output br_taken,
        output br_offset
    );

endinterface

// File: rtl/fetch_branch_target_adder.sv
// Next-PC computation for an accepted instruction: either the sequential
// successor or the branch target. All arithmetic wraps modulo 2^64.
module branch_target_adder
    import fetch_pkg::*;
(
    input  logic [ADDR_W-1:0] pc,
    input  logic [ADDR_W-1:0] br_offset,
    input  logic              br_taken,
    output logic [ADDR_W-1:0] next_pc
);

    // Select between the sequential step and the word-scaled branch offset.
    always_comb begin
        next_pc = pc + PC_STEP;
        if (br_taken) begin
            next_pc = pc + word_to_byte_offset(br_offset);
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: requests one word at the current PC, holds it
// for the decode stage until accepted, then advances or redirects the PC.
// Optional feature macro: FETCH_TIMEOUT_EN adds a fetch-wait counter and a
// sticky FAULT state entered after TIMEOUT_CYCLES memory-wait cycles.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC       = 64'h0,
    parameter int                TIMEOUT_CYCLES = 16
) (
    input  logic      clk,
    input  logic      reset,
    fetch_if.master   bus,
    output logic      fetch_fault
);

    fetch_state_t        state;
    fetch_state_t        state_next;

    logic [ADDR_W-1:0]   pc;
    logic [ADDR_W-1:0]   next_pc;
    logic [INSTR_W-1:0]  instr_q;
    logic [ADDR_W-1:0]   instr_pc_q;

    logic                imem_req_c;
    logic                instr_valid_c;
    logic                capture;
    logic                accept;

`ifdef FETCH_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0]    wait_cnt;
    logic                timeout_hit;
    logic                fault_q;

    // The last permitted empty FETCH cycle is the one where the count is one short.
    assign timeout_hit = (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`endif

    // State register; reset always lands in IDLE so a pending request is dropped.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and handshake outputs; memory responses count only in FETCH.
    always_comb begin
        state_next    = state;
        imem_req_c    = 1'b0;
        instr_valid_c = 1'b0;
        capture       = 1'b0;
        accept        = 1'b0;
        case (state)
            IDLE: begin
                state_next = FETCH;
            end
            FETCH: begin
                imem_req_c = 1'b1;
                if (bus.imem_valid) begin
                    capture    = 1'b1;
                    state_next = HOLD;
                end
`ifdef FETCH_TIMEOUT_EN
                else if (timeout_hit) begin
                    state_next = FAULT;
                end
`endif
            end
            HOLD: begin
                instr_valid_c = 1'b1;
                if (bus.instr_ready) begin
                    accept     = 1'b1;
                    state_next = FETCH;
                end
            end
`ifdef FETCH_TIMEOUT_EN
            FAULT: begin
                state_next = FAULT;
            end
`endif
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // PC and held-instruction registers; branch inputs matter only on accept.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc         <= RESET_PC;
            instr_q    <= '0;
            instr_pc_q <= '0;
        end else begin
            if (capture) begin
                instr_q    <= bus.imem_rdata;
                instr_pc_q <= pc;
            end
            if (accept) begin
                pc <= next_pc;
            end
        end
    end

    branch_target_adder u_branch_target_adder (
        .pc        (instr_pc_q),
        .br_offset (bus.br_offset),
        .br_taken  (bus.br_taken),
        .next_pc   (next_pc)
    );

`ifdef FETCH_TIMEOUT_EN
    // Wait counter is zero outside FETCH, so it starts clean on every entry; fault is sticky.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wait_cnt <= '0;
            fault_q  <= 1'b0;
        end else begin
            if (state != FETCH) begin
                wait_cnt <= '0;
            end else if (!bus.imem_valid) begin
                wait_cnt <= wait_cnt + CNT_W'(1);
                if (timeout_hit) begin
                    fault_q <= 1'b1;
                end
            end
        end
    end

    assign fetch_fault = fault_q;
`else
    logic unused_timeout_cfg;

    assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
    assign fetch_fault        = 1'b0;
`endif

    assign bus.imem_req    = imem_req_c;
    assign bus.imem_addr   = pc;
    assign bus.instr_valid = instr_valid_c;
    assign bus.instr_out   = instr_q;
    assign bus.instr_pc    = instr_pc_q;

endmodule
